generator_collector: RTL
========================

Name: generator_collector

Overview:
- Consumer end of the generated-generator stream protocol (_start / _out0 / _valid / _done).
- Launches one generator run with a single-cycle _gen_start pulse, then captures every valid output word into a local buffer while keeping a running count and signed sum.
- After the generator signals done, replays the captured words in order to a host over a valid/ready port.
- Sits between a generated producer module and host/testbench logic, letting generators be checked and consumed in hardware.

Parameters:
- WIDTH, 32, data width of generator output words, treated as signed.
- DEPTH, 16, buffer entries; power of two, minimum 2.
- SUM_W, 48, width of the running signed sum accumulator.

Ports:
- _clock  input  1  rising-edge clock.
- _reset  input  1  asynchronous, active-high reset.
- _go  input  1  host request to start one run; sampled only in IDLE.
- _busy  output  1  high in every state except IDLE.
- _gen_start  output  1  drives the producer's _start.
- _gen_out0  input  WIDTH  producer data.
- _gen_valid  input  1  producer data valid.
- _gen_done  input  1  producer finished.
- _count  output  clog2(DEPTH+1)  number of words stored this run.
- _sum  output  SUM_W  signed sum of the stored words.
- _overflow  output  1  set if more than DEPTH valid words arrived in this run.
- _finished  output  1  one-cycle pulse when collection ends.
- _rd_data  output  WIDTH  replayed word.
- _rd_valid  output  1  _rd_data is valid.
- _rd_ready  input  1  host accepts _rd_data.

Behaviour:
- Reset: on _reset high, asynchronously go to IDLE and drive every output to 0. Write and read pointers clear. Buffer contents are don't-care. Reset in any state aborts the run; no _finished pulse is issued.
- All outputs are registered.
- FSM states: IDLE, START, COLLECT, DRAIN.
- IDLE:
  - _busy=0, _gen_start=0.
  - _go=1 moves to START next cycle.
  - _count, _sum and _overflow hold the previous run's values until the next START.
- START (exactly one cycle):
  - _gen_start=1.
  - _count, _sum, _overflow, write pointer and read pointer clear to 0.
  - _gen_valid and _gen_done are ignored in this cycle.
  - Next state is COLLECT; _gen_start returns to 0.
- COLLECT:
  - Each cycle with _gen_valid=1:
    - If _count<DEPTH: write _gen_out0 to buf[_count], increment _count, and add _gen_out0 to _sum.
    - Else: drop the word, set _overflow=1 (sticky for the run), leave _sum unchanged.
  - Sum arithmetic: _gen_out0 is sign-extended to SUM_W. The sum wraps modulo 2^SUM_W; there is no saturation.
  - _gen_done=1 moves to DRAIN and pulses _finished for one cycle, in the cycle after _gen_done is sampled.
  - If _gen_valid=1 and _gen_done=1 in the same cycle, the word is stored first, then the transition happens.
  - _go is ignored.
- DRAIN:
  - _rd_valid=1 while read pointer < _count; _rd_data=buf[read pointer].
  - A transfer happens on _rd_valid && _rd_ready; the read pointer then increments.
  - _rd_data and _rd_valid hold stable while _rd_valid=1 and _rd_ready=0.
  - When read pointer == _count (including _count=0 immediately), go to IDLE the next cycle with _rd_valid=0.
  - _go is ignored.
- Latency:
  - _gen_start is asserted 1 cycle after _go is sampled.
  - A word on _gen_out0 appears in _count/_sum 1 cycle after capture.
  - The first _rd_valid appears in the same cycle as the _finished pulse.
  - Throughput: 1 word per cycle in both directions.

Test Plan:
- Producer emits 3, -1, 7 with idle gaps, then done -> _finished pulses once; _count=3, _sum=9, _overflow=0; readback 3, -1, 7 with _rd_ready=1; _busy falls 1 cycle after the last transfer.
- Producer asserts done immediately after START with no valid words -> _finished pulses; _count=0, _sum=0; _rd_valid never rises; back to IDLE 1 cycle later.
- DEPTH=4, producer emits 1..6 -> _count=4, _sum=10, _overflow=1; readback 1, 2, 3, 4 only.
- Last word 42 arrives with _gen_valid and _gen_done in the same cycle, after 5 -> _count=2, _sum=47, readback 5, 42.
- Backpressure: toggle _rd_ready pseudo-randomly during DRAIN -> _rd_data stable while stalled, no word lost or duplicated; _go pulsed during DRAIN has no effect.
- Assert _reset mid-COLLECT after 2 words -> all outputs 0 and state IDLE immediately; a following run with 8, 8 yields _count=2, _sum=16, _overflow=0.

Source files
------------

// File: rtl/generator_collector_if.sv
// ----------------------------------------------------------------------------
// generator_collector_if : producer, host-control and readback signal bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface generator_collector_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SUM_W = 48,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             _go;
  logic             _busy;
  logic             _gen_start;
  logic [WIDTH-1:0] _gen_out0;
  logic             _gen_valid;
  logic             _gen_done;
  logic [CNT_W-1:0] _count;
  logic [SUM_W-1:0] _sum;
  logic             _overflow;
  logic             _finished;
  logic [WIDTH-1:0] _rd_data;
  logic             _rd_valid;
  logic             _rd_ready;

  modport slave (
    input  _go, _gen_out0, _gen_valid, _gen_done, _rd_ready,
    output _busy, _gen_start, _count, _sum, _overflow, _finished,
           _rd_data, _rd_valid
  );

  modport master (
    output _go, _gen_out0, _gen_valid, _gen_done, _rd_ready,
    input  _busy, _gen_start, _count, _sum, _overflow, _finished,
           _rd_data, _rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/generator_collector.sv
// ----------------------------------------------------------------------------
// generator_collector : launches a generator run, buffers its words, replays them
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module generator_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SUM_W = 48
) (
  input  wire logic            _clock,
  input  wire logic            _reset,
  generator_collector_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_start   = 2'd1;
  localparam logic [1:0] c_collect = 2'd2;
  localparam logic [1:0] c_drain   = 2'd3;

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [CNT_W-1:0] r_rd_ptr, w_rd_ptr_nxt, w_rd_ptr_inc;
  logic [SUM_W-1:0] r_sum, w_sum_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic             r_finished, r_gen_start, r_busy;
  logic             r_rd_valid, w_rd_valid_nxt;
  logic [WIDTH-1:0] r_rd_data, w_rd_data_nxt;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic             w_wr_en, w_xfer;

  assign w_wr_en      = (r_state == c_collect) && bus._gen_valid && (r_count < c_depth);
  assign w_xfer       = r_rd_valid && bus._rd_ready;
  assign w_rd_ptr_inc = r_rd_ptr + CNT_W'(w_xfer);

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) r_state <= c_idle;
    else        r_state <= w_state_nxt;
  end

  // Leaving DRAIN looks at the post-transfer pointer so _busy drops right after the last word
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:    if (bus._go) w_state_nxt = c_start;
      c_start:   w_state_nxt = c_collect;
      c_collect: if (bus._gen_done) w_state_nxt = c_drain;
      c_drain:   if (w_rd_ptr_inc == r_count) w_state_nxt = c_idle;
      default:   w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_count_nxt    = r_count;
    w_sum_nxt      = r_sum;
    w_overflow_nxt = r_overflow;
    w_rd_ptr_nxt   = r_rd_ptr;
    if (r_state == c_idle && w_state_nxt == c_start) begin
      w_count_nxt    = '0;
      w_sum_nxt      = '0;
      w_overflow_nxt = 1'b0;
      w_rd_ptr_nxt   = '0;
    end
    if (w_wr_en) begin
      w_count_nxt = r_count + CNT_W'(1);
      w_sum_nxt   = r_sum + SUM_W'(signed'(bus._gen_out0));
    end
    if (r_state == c_collect && bus._gen_valid && !w_wr_en) w_overflow_nxt = 1'b1;
    if (r_state == c_drain) w_rd_ptr_nxt = w_rd_ptr_inc;
    w_rd_valid_nxt = (w_state_nxt == c_drain) && (w_rd_ptr_nxt < w_count_nxt);
    w_rd_data_nxt  = r_rd_data;
    // A word stored on the same edge that enters DRAIN is not yet in r_buf
    if (w_rd_valid_nxt) begin
      if (w_wr_en && (r_count[AW-1:0] == w_rd_ptr_nxt[AW-1:0]))
        w_rd_data_nxt = bus._gen_out0;
      else
        w_rd_data_nxt = r_buf[w_rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge _clock) begin
    if (w_wr_en) r_buf[r_count[AW-1:0]] <= bus._gen_out0;
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      r_count     <= '0;
      r_sum       <= '0;
      r_overflow  <= 1'b0;
      r_rd_ptr    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_finished  <= 1'b0;
      r_gen_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_sum       <= w_sum_nxt;
      r_overflow  <= w_overflow_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_finished  <= (r_state == c_collect) && (w_state_nxt == c_drain);
      r_gen_start <= (w_state_nxt == c_start);
      r_busy      <= (w_state_nxt != c_idle);
    end
  end

  assign bus._busy      = r_busy;
  assign bus._gen_start = r_gen_start;
  assign bus._count     = r_count;
  assign bus._sum       = r_sum;
  assign bus._overflow  = r_overflow;
  assign bus._finished  = r_finished;
  assign bus._rd_data   = r_rd_data;
  assign bus._rd_valid  = r_rd_valid;
endmodule

`default_nettype wire
